// File: rtl/master_port.sv
// Bit-serial bus master port: serializes one read/write request MSB-first and collects read data.
// Optional read-wait timeout enabled by defining MASTER_PORT_TIMEOUT_EN.
module master_port #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  input  logic                  slave_ready,
  input  logic                  rd_bus,
  input  logic                  slave_valid,
  output logic                  master_ready
);

  localparam int unsigned SW = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_WAIT_RD = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rd_sh_q, rd_sh_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  mode_q, mode_d;
  logic                  wr_bus_q, wr_bus_d;
  logic                  mv_q, mv_d;
  logic                  mr_q, mr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  beat, rx_bit;

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]         wait_q, wait_d;
`endif

  assign beat   = mv_q && slave_ready;
  assign rx_bit = mr_q && slave_valid;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rd_sh_d     = rd_sh_q;
    rsp_rdata_d = rsp_rdata_q;
    mode_d      = mode_q;
    rsp_err_d   = 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
    wait_d      = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mode_d  = req_mode;
          sh_d    = {req_addr, req_wdata};
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (beat) begin
          sh_d = sh_q << 1;
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = mode_q ? S_DATA : S_WAIT_RD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (beat) begin
          sh_d = sh_q << 1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WAIT_RD: begin
        if (rx_bit) begin
          rd_sh_d = (rd_sh_q << 1) | DATA_WIDTH'(rd_bus);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d       = '0;
            rsp_rdata_d = rd_sh_d;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef MASTER_PORT_TIMEOUT_EN
        else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d       = '0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mv_d        = (state_d == S_ADDR) || (state_d == S_DATA);
    mr_d        = (state_d == S_WAIT_RD);
    wr_bus_d    = mv_d ? sh_d[SW-1] : 1'b0;
    rsp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      rd_sh_q     <= '0;
      rsp_rdata_q <= '0;
      mode_q      <= 1'b0;
      wr_bus_q    <= 1'b0;
      mv_q        <= 1'b0;
      mr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rd_sh_q     <= rd_sh_d;
      rsp_rdata_q <= rsp_rdata_d;
      mode_q      <= mode_d;
      wr_bus_q    <= wr_bus_d;
      mv_q        <= mv_d;
      mr_q        <= mr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
`ifdef MASTER_PORT_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  // req_ready is decoded straight from state so the port is visibly ready right after reset
  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign mode         = mode_q;
  assign wr_bus       = wr_bus_q;
  assign master_valid = mv_q;
  assign master_ready = mr_q;
`ifdef MASTER_PORT_TIMEOUT_EN
  assign rsp_err      = rsp_err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_master_port.sv
// Directed self-checking bench for master_port; the bench acts as the serial slave.
module tb_master_port;

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_mode;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err, mode;
  logic [7:0]  rsp_rdata;
  logic        wr_bus, master_valid, slave_ready;
  logic        rd_bus, slave_valid, master_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic busy_bad, mode_bad, mv_wait_bad, hold_bad;

  master_port #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid),
    .slave_ready(slave_ready), .rd_bus(rd_bus), .slave_valid(slave_valid),
    .master_ready(master_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction; latency counts the accept cycle as cycle 1.
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd_val, input int stall_at, input int stall_len,
                        input int rd_delay, input int abort_at, input logic hold,
                        output int lat, output int acc_wait, output logic [23:0] bits,
                        output logic got_rsp);
    logic [23:0] seq;
    logic        prev_mv, rdy;
    int          cyc, beats, stalled, rx, wcyc;
    seq = wr ? {addr, wd} : {addr, 8'h00};
    busy_bad = 0; mode_bad = 0; mv_wait_bad = 0; hold_bad = 0;
    lat = 0; bits = '0; got_rsp = 0; acc_wait = 0;
    req_mode = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && acc_wait < 50) begin
      @(posedge clk); #1; acc_wait++;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    cyc = 1; beats = 0; stalled = 0; rx = 0; wcyc = 0; prev_mv = 0;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid) begin
        got_rsp = 1; lat = cyc + 1;
        break;
      end
      if (req_ready) busy_bad = 1;
      if ((master_valid || master_ready) && mode !== wr) mode_bad = 1;
      if (master_ready && master_valid) mv_wait_bad = 1;
      rdy = 1'b0;
      if (master_valid) begin
        if (wr_bus !== seq[23-beats]) hold_bad = 1;
        if (abort_at >= 0 && beats == 16 + abort_at) begin
          rst = 1'b1; slave_ready = 1'b0;
          @(posedge clk); #1;
          check("abort_mv", 32'(master_valid), 32'd0);
          check("abort_rsp", 32'(rsp_valid), 32'd0);
          check("abort_idle", 32'(req_ready), 32'd1);
          rst = 1'b0;
          return;
        end
        rdy = prev_mv && !(beats == stall_at && stalled < stall_len);
        if (prev_mv && !rdy) stalled++;
        if (rdy) begin
          bits = {bits[22:0], wr_bus};
          beats++;
        end
      end
      slave_ready = rdy;
      prev_mv = master_valid;
      slave_valid = 1'b0;
      if (master_ready) begin
        if (wcyc >= rd_delay && rx < 8) begin
          slave_valid = 1'b1;
          rd_bus = rd_val[7-rx];
          rx++;
        end
        wcyc++;
      end
      @(posedge clk); #1; cyc++;
    end
    slave_ready = 1'b0; slave_valid = 1'b0;
  endtask

  int          lat, accw;
  logic [23:0] bits;
  logic        got;
  logic        seen;

  initial begin
    rst = 1'b1; req_valid = 0; req_mode = 0; req_addr = '0; req_wdata = '0;
    slave_ready = 0; rd_bus = 0; slave_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mv", 32'(master_valid), 32'd0);
    check("rst_mr", 32'(master_ready), 32'd0);
    check("rst_wr_bus", 32'(wr_bus), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain write
    do_txn(1, 16'h0012, 8'hA5, 8'h00, -1, 0, 0, -1, 0, lat, accw, bits, got);
    check("w1_rsp", 32'(got), 32'd1);
    check("w1_bits", 32'(bits), 32'h0012A5);
    check("w1_lat", 32'(lat), 32'd27);
    check("w1_mode", 32'(mode_bad), 32'd0);
    check("w1_busy", 32'(busy_bad), 32'd0);
    check("w1_hold", 32'(hold_bad), 32'd0);
    check("w1_err", 32'(rsp_err), 32'd0);
    check("w1_rdata", 32'(rsp_rdata), 32'd0);

    // Read returning 0x3C
    do_txn(0, 16'h0003, 8'h00, 8'h3C, -1, 0, 0, -1, 0, lat, accw, bits, got);
    check("r1_rsp", 32'(got), 32'd1);
    check("r1_addr", 32'(bits[15:0]), 32'h0003);
    check("r1_rdata", 32'(rsp_rdata), 32'h3C);
    check("r1_err", 32'(rsp_err), 32'd0);
    check("r1_mode", 32'(mode_bad), 32'd0);
    check("r1_mv_wait", 32'(mv_wait_bad), 32'd0);
    check("r1_lat", 32'(lat), 32'd27);

    // Write with a 3-cycle stall on bit 5
    do_txn(1, 16'hBEEF, 8'h5A, 8'h00, 5, 3, 0, -1, 0, lat, accw, bits, got);
    check("ws_bits", 32'(bits), 32'hBEEF5A);
    check("ws_lat", 32'(lat), 32'd30);
    check("ws_hold", 32'(hold_bad), 32'd0);
    check("ws_rdata_kept", 32'(rsp_rdata), 32'h3C);

    // Back-to-back writes with req_valid held
    do_txn(1, 16'h1234, 8'h0F, 8'h00, -1, 0, 0, -1, 1, lat, accw, bits, got);
    check("bb1_bits", 32'(bits), 32'h12340F);
    check("bb1_busy", 32'(busy_bad), 32'd0);
    do_txn(1, 16'h8001, 8'hC3, 8'h00, -1, 0, 0, -1, 0, lat, accw, bits, got);
    check("bb2_accept_wait", 32'(accw), 32'd1);
    check("bb2_bits", 32'(bits), 32'h8001C3);
    check("bb2_lat", 32'(lat), 32'd27);

    // Reset during data bit 3, then a clean write
    do_txn(1, 16'h00FF, 8'h81, 8'h00, -1, 0, 0, 3, 0, lat, accw, bits, got);
    check("abort_no_rsp", 32'(got), 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid || master_valid) seen = 1;
      @(posedge clk); #1;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    do_txn(1, 16'h4321, 8'h66, 8'h00, -1, 0, 0, -1, 0, lat, accw, bits, got);
    check("post_abort_bits", 32'(bits), 32'h432166);
    check("post_abort_lat", 32'(lat), 32'd27);

`ifdef MASTER_PORT_TIMEOUT_EN
    // Read with no slave response
    do_txn(0, 16'h0007, 8'h00, 8'hFF, -1, 0, 1000, -1, 0, lat, accw, bits, got);
    check("to_rsp", 32'(got), 32'd1);
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_rdata", 32'(rsp_rdata), 32'd0);
    check("to_lat", 32'(lat), 32'd27);
`else
    // Read where the slave answers late
    do_txn(0, 16'h0007, 8'h00, 8'h96, -1, 0, 20, -1, 0, lat, accw, bits, got);
    check("rl_rsp", 32'(got), 32'd1);
    check("rl_rdata", 32'(rsp_rdata), 32'h96);
    check("rl_err", 32'(rsp_err), 32'd0);
    check("rl_lat", 32'(lat), 32'd47);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
